ser_frame_demux: RTL and testbench
==================================

Name: ser_frame_demux

Overview:
- Serial frame receiver/demultiplexer; successor to the fixed 4-port serial receiver.
- Frame format on one serial line: start bit, port address, payload length, payload, optional parity bit.
- Payload bits are steered to one of N_PORTS outputs with a valid strobe; the frame is then held until the consumer acknowledges with `transmitted`.
- Sits between the serial link pin and per-port consumers.

Parameters:
- PORT_BITS, 2, width of the address field; N_PORTS = 2**PORT_BITS.
- LEN_BITS, 4, width of the length field; a payload carries 0 to 2**LEN_BITS-1 bits.
- PARITY_EN, 0, 1 = an even-parity bit follows the payload and is checked.

Ports:
- clk  in  1  system clock; all sampling on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- serIn  in  1  serial line; idles high.
- transmitted  in  1  consumer acknowledge; releases the DONE state.
- serOut  out  N_PORTS  routed payload bit; only the addressed bit is live.
- serOutValid  out  1  high while a payload bit is present on serOut.
- done  out  1  frame complete, waiting for acknowledge.
- parErr  out  1  parity mismatch on the last frame (PARITY_EN=1 only).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counters/port/length registers=0, parErr=0.
  - All outputs are 0 while in reset.
  - Deassertion takes effect at the next clock.
  - Reset mid-frame aborts the frame; no done pulse is produced.
- States: IDLE, PORT, LEN, DATA, PAR, DONE.
- IDLE:
  - serIn=0 sampled → PORT, clear bit counter, clear parErr.
  - serIn=1 → stay in IDLE.
- PORT:
  - Shift serIn into the port register, MSB first.
  - After PORT_BITS cycles → LEN.
- LEN:
  - Shift serIn into the length register, MSB first.
  - After LEN_BITS cycles: length≠0 → DATA; length=0 → PAR if PARITY_EN else DONE.
- DATA:
  - Combinational (zero latency): serOutValid=1; serOut[port]=serIn; all other serOut bits=0.
  - Data counter increments each cycle; running XOR of payload bits is kept.
  - After exactly `length` cycles → PAR if PARITY_EN else DONE.
- PAR:
  - One cycle; serOutValid=0.
  - parErr <= (XOR of payload) ^ serIn. A correct bit makes total ones even.
  - → DONE.
- DONE:
  - done=1.
  - transmitted=1 sampled → IDLE.
  - Otherwise stay in DONE; serIn is ignored, including start bits.
  - transmitted in any state other than DONE has no effect.
- parErr is registered and holds until the next start bit or reset.
- serOutValid and serOut are 0 in every state except DATA.
- busy = (state≠IDLE).
- Counters are sized to ceil(log2) of their limits.
- Maximum length (2**LEN_BITS-1) must not wrap the data counter early.
- Back-to-back frames:
  - A start bit is recognised only once back in IDLE.
  - The earliest new start bit is the cycle after the one in which transmitted was sampled high in DONE.

Test Plan (PORT_BITS=2, LEN_BITS=4 unless stated):
1. PARITY_EN=0, serIn idle 1 then 0,01,0110,101100.
   - Cycles 7–12 after start: serOutValid=1, serOut=0010·serIn, others 0.
   - Cycle 13 onward: done=1, held; transmitted=1 → IDLE next cycle.
2. Length 0 frame (0,11,0000).
   - No serOutValid.
   - done=1 in cycle 7 after start.
3. PARITY_EN=1, payload 1011 with parity 1 → parErr=0. Same payload with parity 0 → parErr=1, holding until the next start bit.
4. Start bit sent while in DONE with transmitted=0 → ignored, done stays 1. After acknowledge, the next start is decoded correctly on port 2.
5. rst pulsed low mid-DATA → outputs 0 immediately. The following frame to port 3 with length 15 passes 15 valid bits, then done.
6. PORT_BITS=3, LEN_BITS=5: frame to port 6, length 20 → serOut[6] valid 20 cycles, no other bit ever set.

Source files
------------

// File: rtl/ser_frame_demux.sv
// ser_frame_demux
//   Serial frame receiver / demultiplexer. A frame on serIn is
//   start bit (0), PORT_BITS address, LEN_BITS length, `length` payload bits
//   and, when PARITY_EN=1, one even-parity bit. Payload bits are steered
//   combinationally to serOut[port] with serOutValid. The receiver then holds
//   in DONE until the consumer acknowledges with `transmitted`.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   serIn        serial line, idles high
//   transmitted  consumer acknowledge, only sampled in DONE
//   serOut       routed payload bit, one-hot position = addressed port
//   serOutValid  payload bit present on serOut
//   done         frame complete, waiting for acknowledge
//   parErr       parity mismatch on the last frame (held until next start bit)
//   busy         receiver not idle
module ser_frame_demux #(
    parameter int unsigned PORT_BITS = 2,
    parameter int unsigned LEN_BITS  = 4,
    parameter int unsigned PARITY_EN = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      serIn,
    input  logic                      transmitted,
    output logic [2**PORT_BITS-1:0]   serOut,
    output logic                      serOutValid,
    output logic                      done,
    output logic                      parErr,
    output logic                      busy
);

    localparam int unsigned FIELD_MAX = (PORT_BITS > LEN_BITS) ? PORT_BITS : LEN_BITS;
    localparam int unsigned BW        = $clog2(FIELD_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PORT,
        S_LEN,
        S_DATA,
        S_PAR,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [BW-1:0]          bcnt;
    logic [PORT_BITS-1:0]   port_r;
    logic [LEN_BITS-1:0]    len_r;
    logic [LEN_BITS-1:0]    len_shift;
    logic [LEN_BITS-1:0]    dcnt;
    logic                   par_acc;
    logic                   port_last;
    logic                   len_last;
    logic                   data_last;

    // Length as it will be once the current bit is shifted in; the LEN exit
    // decision needs the complete field in the same cycle as its last bit.
    always_comb begin
        len_shift = LEN_BITS'({len_r, serIn});
        port_last = (bcnt == BW'(PORT_BITS - 1));
        len_last  = (bcnt == BW'(LEN_BITS - 1));
        // dcnt counts 0..length-1, so the maximum length never needs the
        // counter to reach 2**LEN_BITS and cannot wrap early.
        data_last = (dcnt == len_r - LEN_BITS'(1));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (!serIn) state_nxt = S_PORT;
            S_PORT: if (port_last) state_nxt = S_LEN;
            S_LEN: begin
                if (len_last) begin
                    if (len_shift != '0)      state_nxt = S_DATA;
                    else if (PARITY_EN != 0)  state_nxt = S_PAR;
                    else                      state_nxt = S_DONE;
                end
            end
            S_DATA: begin
                if (data_last) begin
                    if (PARITY_EN != 0) state_nxt = S_PAR;
                    else                state_nxt = S_DONE;
                end
            end
            S_PAR:  state_nxt = S_DONE;
            S_DONE: if (transmitted) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        serOut      = '0;
        serOutValid = 1'b0;
        done        = (state == S_DONE);
        busy        = (state != S_IDLE);
        if (state == S_DATA) begin
            serOutValid    = 1'b1;
            serOut[port_r] = serIn;
        end
    end

    // Field registers, counters and parity
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt    <= '0;
            port_r  <= '0;
            len_r   <= '0;
            dcnt    <= '0;
            par_acc <= 1'b0;
            parErr  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!serIn) begin
                        bcnt   <= '0;
                        parErr <= 1'b0;
                    end
                end
                S_PORT: begin
                    port_r <= PORT_BITS'({port_r, serIn});
                    bcnt   <= port_last ? '0 : bcnt + BW'(1);
                end
                S_LEN: begin
                    len_r   <= len_shift;
                    bcnt    <= len_last ? '0 : bcnt + BW'(1);
                    dcnt    <= '0;
                    par_acc <= 1'b0;
                end
                S_DATA: begin
                    dcnt    <= dcnt + LEN_BITS'(1);
                    par_acc <= par_acc ^ serIn;
                end
                S_PAR: begin
                    if (PARITY_EN != 0) parErr <= par_acc ^ serIn;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ser_frame_demux.sv
// tb_ser_frame_demux
//   Three receivers: (2,4,no parity), (2,4,parity), (3,5,no parity).
//   Frames are built as bit streams and expected outputs are derived per
//   cycle from the frame layout (position in stream -> phase).
module tb_ser_frame_demux;

    logic       clk = 1'b0;
    logic [2:0] rst_n;
    logic [2:0] ser_in;
    logic [2:0] trans;
    logic [3:0] so0, so1;
    logic [7:0] so2;
    logic [2:0] vld, dn, pe, bsy;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    logic [2:0]  exp_par;

    int unsigned PB[3] = '{2, 2, 3};
    int unsigned LB[3] = '{4, 4, 5};
    int unsigned PE[3] = '{0, 1, 0};

    always #5 clk = ~clk;

    ser_frame_demux #(.PORT_BITS(2), .LEN_BITS(4), .PARITY_EN(0)) u_dut0 (
        .clk(clk), .rst(rst_n[0]), .serIn(ser_in[0]), .transmitted(trans[0]),
        .serOut(so0), .serOutValid(vld[0]), .done(dn[0]), .parErr(pe[0]), .busy(bsy[0])
    );
    ser_frame_demux #(.PORT_BITS(2), .LEN_BITS(4), .PARITY_EN(1)) u_dut1 (
        .clk(clk), .rst(rst_n[1]), .serIn(ser_in[1]), .transmitted(trans[1]),
        .serOut(so1), .serOutValid(vld[1]), .done(dn[1]), .parErr(pe[1]), .busy(bsy[1])
    );
    ser_frame_demux #(.PORT_BITS(3), .LEN_BITS(5), .PARITY_EN(0)) u_dut2 (
        .clk(clk), .rst(rst_n[2]), .serIn(ser_in[2]), .transmitted(trans[2]),
        .serOut(so2), .serOutValid(vld[2]), .done(dn[2]), .parErr(pe[2]), .busy(bsy[2])
    );

    // {done, parErr, busy, valid, serOut[7:0]}
    function automatic logic [11:0] obs(input int unsigned k);
        case (k)
            0:       return {dn[0], pe[0], bsy[0], vld[0], 4'b0, so0};
            1:       return {dn[1], pe[1], bsy[1], vld[1], 4'b0, so1};
            default: return {dn[2], pe[2], bsy[2], vld[2], so2};
        endcase
    endfunction

    function automatic logic [11:0] mk(input logic d, input logic p, input logic b,
                                       input logic v, input logic [7:0] s);
        return {d, p, b, v, s};
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int unsigned k, input int unsigned n);
        for (int unsigned c = 0; c < n; c++) begin
            @(negedge clk);
            ser_in[k] = 1'b1;
            trans[k]  = 1'($urandom);
            #1;
            check($sformatf("idle i%0d", k), obs(k), mk(1'b0, exp_par[k], 1'b0, 1'b0, 8'h00));
        end
    endtask

    // Sends one frame on instance k, then acknowledges after ack_wait DONE
    // cycles; the first `zeros` DONE cycles carry serIn=0 (spurious starts).
    // abort_at >= 0 pulses reset after that stream cycle and ends the frame.
    task automatic run_frame(input int unsigned k, input int unsigned port,
                             input int unsigned len, input logic [31:0] pv,
                             input logic pbit, input int unsigned ack_wait,
                             input int unsigned zeros, input int abort_at);
        logic         q[$];
        int unsigned  d0;
        logic         par;
        logic         v;
        logic [7:0]   s;
        q.push_back(1'b0);
        for (int b = int'(PB[k]) - 1; b >= 0; b--) q.push_back(1'(port >> b));
        for (int b = int'(LB[k]) - 1; b >= 0; b--) q.push_back(1'(len >> b));
        for (int j = 0; j < int'(len); j++) q.push_back(pv[int'(len) - 1 - j]);
        if (PE[k] != 0) q.push_back(pbit);
        d0  = 1 + PB[k] + LB[k];
        par = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            ser_in[k] = q[i];
            trans[k]  = 1'($urandom);
            #1;
            v = (i >= int'(d0)) && (i < int'(d0 + len));
            if (v) par ^= q[i];
            s = v ? (8'(q[i]) << port) : 8'h00;
            check($sformatf("frm i%0d c%0d", k, i), obs(k),
                  mk(1'b0, (i == 0) ? exp_par[k] : 1'b0, i > 0, v, s));
            if (i == abort_at) begin
                rst_n[k] = 1'b0;
                #1;
                check($sformatf("rst i%0d", k), obs(k), 12'h000);
                @(negedge clk);
                check($sformatf("rst hold i%0d", k), obs(k), 12'h000);
                rst_n[k]   = 1'b1;
                ser_in[k]  = 1'b1;
                trans[k]   = 1'b0;
                exp_par[k] = 1'b0;
                return;
            end
        end
        exp_par[k] = (PE[k] != 0) ? (par ^ pbit) : 1'b0;
        for (int unsigned j = 0; j <= ack_wait; j++) begin
            @(negedge clk);
            ser_in[k] = (j < zeros) ? 1'b0 : 1'($urandom);
            trans[k]  = (j == ack_wait);
            #1;
            check($sformatf("done i%0d w%0d", k, j), obs(k), mk(1'b1, exp_par[k], 1'b1, 1'b0, 8'h00));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned pt, ln, aw;
        rst_n   = '0;
        ser_in  = '1;
        trans   = '0;
        exp_par = '0;
        @(negedge clk);
        ser_in = '0;
        trans  = '1;
        #1;
        for (int unsigned k = 0; k < 3; k++) check($sformatf("reset i%0d", k), obs(k), 12'h000);
        @(negedge clk);
        rst_n  = '1;
        ser_in = '1;
        trans  = '0;
        for (int unsigned k = 0; k < 3; k++) idle(k, 2);

        // Plan 1: port 1, length 6, payload 101100; held DONE 3 cycles
        run_frame(0, 1, 6, 32'b101100, 1'b0, 3, 0, -1);
        idle(0, 1);
        // Plan 2: length 0 to port 3
        run_frame(0, 3, 0, 32'h0, 1'b0, 1, 0, -1);
        // Plan 4: start bits while in DONE ignored, then back-to-back to port 2
        run_frame(0, 1, 3, 32'b011, 1'b0, 4, 5, -1);
        run_frame(0, 2, 5, 32'b11010, 1'b0, 0, 0, -1);
        idle(0, 1);
        // Plan 5: reset mid-DATA, then port 3 with maximum length
        run_frame(0, 1, 10, 32'h2A5, 1'b0, 0, 0, 10);
        idle(0, 1);
        run_frame(0, 3, 15, 32'h5B3C, 1'b0, 1, 0, -1);
        idle(0, 1);

        // Plan 3: parity correct then wrong; parErr holds across idle
        run_frame(1, 2, 4, 32'b1011, 1'b1, 1, 0, -1);
        idle(1, 2);
        run_frame(1, 2, 4, 32'b1011, 1'b0, 2, 0, -1);
        idle(1, 3);
        run_frame(1, 0, 0, 32'h0, 1'b1, 0, 0, -1);
        idle(1, 1);
        run_frame(1, 1, 15, 32'h7FFF, 1'b1, 0, 0, -1);

        // Plan 6: wide config, port 6, length 20
        run_frame(2, 6, 20, 32'hA5F31, 1'b0, 2, 0, -1);
        idle(2, 1);

        // Randomized frames on every instance
        for (int unsigned k = 0; k < 3; k++) begin
            for (int n = 0; n < 25; n++) begin
                pt = $urandom_range((1 << PB[k]) - 1, 0);
                ln = $urandom_range((1 << LB[k]) - 1, 0);
                aw = $urandom_range(3, 0);
                run_frame(k, pt, ln, $urandom, 1'($urandom), aw, $urandom_range(aw + 1, 0), -1);
                idle(k, $urandom_range(2, 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
